inert_poll: RTL

- Producer side of the inertial data path.
- After reset, configures the 6-axis inertial sensor over SPI, then waits for each sensor data-ready interrupt (INT).
- On each interrupt, reads roll rate, yaw rate, AY and AZ as 8 byte-register reads, assembles four signed 16-bit words, and pulses vld for one clk.
- Sits between the sensor pins and the incline/roll integrator; its vld/roll_rt/yaw_rt/AY/AZ drive that integrator directly.

---
 rtl/inert_poll.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/inert_poll.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inert_poll : SPI producer for the 6-axis inertial sensor; configures it after
// power-up, then reads roll/yaw rate and AY/AZ on every INT.
// Optional watchdog: define INERT_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------------------
module inert_poll #(
    parameter int SCLK_DIV    = 16,
    parameter int PWRUP_CYC   = 65536,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    input  logic        INT,
    output logic        vld,
    output logic [15:0] roll_rt,
    output logic [15:0] yaw_rt,
    output logic [15:0] AY,
    output logic [15:0] AZ
);
    localparam int DW = $clog2(SCLK_DIV);
    localparam int PW = $clog2(PWRUP_CYC + 1);
    localparam logic [DW-1:0] HALF_M1 = DW'(SCLK_DIV / 2 - 1);
    localparam logic [DW-1:0] FULL_M1 = DW'(SCLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACT, S_GAP} spi_st_t;
    typedef enum logic [2:0] {M_PWRUP, M_INIT, M_WAIT, M_READ, M_DONE} main_st_t;

    spi_st_t       spi_st_q;
    logic [DW-1:0] div_q;
    logic [4:0]    bit_q;
    logic [15:0]   tx_q;
    logic [7:0]    rx_q;
    logic          spi_done_q;
    logic          ss_q, sclk_q, mosi_q;

    main_st_t      st_q;
    logic [PW-1:0] pw_q;
    logic [2:0]    idx_q;
    logic          busy_q;
    logic          int_meta_q, int_sync_q;
    logic [63:0]   hold_q;
    logic          vld_q;
    logic [15:0]   roll_q, yaw_q, ay_q, az_q;

    logic          w_start;
    logic [15:0]   w_cmd;
    logic          w_timeout;

    assign w_start = ((st_q == M_INIT) || (st_q == M_READ)) && (spi_st_q == S_IDLE) && !busy_q;

    always_comb begin
        w_cmd = 16'h0000;
        if (st_q == M_INIT) begin
            case (idx_q[1:0])
                2'd0:    w_cmd = 16'h0D02;
                2'd1:    w_cmd = 16'h1053;
                2'd2:    w_cmd = 16'h1150;
                default: w_cmd = 16'h1460;
            endcase
        end else begin
            case (idx_q)
                3'd0:    w_cmd = 16'hA400;
                3'd1:    w_cmd = 16'hA500;
                3'd2:    w_cmd = 16'hA600;
                3'd3:    w_cmd = 16'hA700;
                3'd4:    w_cmd = 16'hAA00;
                3'd5:    w_cmd = 16'hAB00;
                3'd6:    w_cmd = 16'hAC00;
                default: w_cmd = 16'hAD00;
            endcase
        end
    end

    // SPI engine: SCLK falls at div=HALF, rises at div wrap; a 17th "fall" slot closes the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_st_q   <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            spi_done_q <= 1'b0;
            ss_q       <= 1'b1;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            spi_done_q <= 1'b0;
            case (spi_st_q)
                S_IDLE: begin
                    if (w_start) begin
                        spi_st_q <= S_ACT;
                        ss_q     <= 1'b0;
                        div_q    <= '0;
                        bit_q    <= '0;
                        tx_q     <= w_cmd;
                    end
                end
                S_ACT: begin
                    div_q <= div_q + 1'b1;
                    if (div_q == HALF_M1) begin
                        if (bit_q == 5'd16) begin
                            ss_q       <= 1'b1;
                            spi_done_q <= 1'b1;
                            spi_st_q   <= S_GAP;
                            div_q      <= '0;
                        end else begin
                            sclk_q <= 1'b0;
                            mosi_q <= tx_q[15];
                            tx_q   <= {tx_q[14:0], 1'b0};
                        end
                    end else if (div_q == FULL_M1) begin
                        sclk_q <= 1'b1;
                        rx_q   <= {rx_q[6:0], MISO};
                        bit_q  <= bit_q + 5'd1;
                    end
                end
                S_GAP: begin
                    div_q <= div_q + 1'b1;
                    if (div_q == FULL_M1) begin
                        spi_st_q <= S_IDLE;
                    end
                end
                default: spi_st_q <= S_IDLE;
            endcase
        end
    end

`ifdef INERT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_q;

    assign w_timeout = (st_q == M_WAIT) && (to_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q <= '0;
        end else if ((st_q == M_WAIT) && !w_timeout && !int_sync_q) begin
            to_q <= to_q + 1'b1;
        end else begin
            to_q <= '0;
        end
    end
`else
    // Watchdog absent: TIMEOUT_CYC is referenced only to keep the parameter list uniform.
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= M_PWRUP;
            pw_q       <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
            hold_q     <= '0;
            vld_q      <= 1'b0;
            roll_q     <= '0;
            yaw_q      <= '0;
            ay_q       <= '0;
            az_q       <= '0;
        end else begin
            int_meta_q <= INT;
            int_sync_q <= int_meta_q;
            vld_q      <= 1'b0;
            case (st_q)
                M_PWRUP: begin
                    if (pw_q == PW'(PWRUP_CYC - 1)) begin
                        st_q  <= M_INIT;
                        idx_q <= '0;
                    end else begin
                        pw_q <= pw_q + 1'b1;
                    end
                end
                M_INIT: begin
                    if (w_start) busy_q <= 1'b1;
                    if (spi_done_q) begin
                        busy_q <= 1'b0;
                        idx_q  <= idx_q + 3'd1;
                        if (idx_q == 3'd3) begin
                            st_q  <= M_WAIT;
                            idx_q <= '0;
                        end
                    end
                end
                M_WAIT: begin
                    idx_q <= '0;
                    if (int_sync_q) begin
                        st_q <= M_READ;
                    end else if (w_timeout) begin
                        st_q <= M_INIT;
                    end
                end
                M_READ: begin
                    if (w_start) busy_q <= 1'b1;
                    if (spi_done_q) begin
                        busy_q                       <= 1'b0;
                        hold_q[{idx_q, 3'b000} +: 8] <= rx_q;
                        idx_q                        <= idx_q + 3'd1;
                        if (idx_q == 3'd7) st_q <= M_DONE;
                    end
                end
                M_DONE: begin
                    roll_q <= hold_q[15:0];
                    yaw_q  <= hold_q[31:16];
                    ay_q   <= hold_q[47:32];
                    az_q   <= hold_q[63:48];
                    vld_q  <= 1'b1;
                    st_q   <= M_WAIT;
                end
                default: st_q <= M_PWRUP;
            endcase
        end
    end

    assign SS_n    = ss_q;
    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;
    assign vld     = vld_q;
    assign roll_rt = roll_q;
    assign yaw_rt  = yaw_q;
    assign AY      = ay_q;
    assign AZ      = az_q;

endmodule
`default_nettype wire
